// File: rtl/fifo_capture_ctrl.sv
// Multi-channel ADC-to-FIFO write controller: clears the FIFO, optionally waits
// for a trigger edge, then writes decimated sample sets until length or full.
module fifo_capture_ctrl #(
    parameter int DATA_WIDTH    = 12,
    parameter int NUM_CH        = 2,
    parameter int LEN_BITS      = 12,
    parameter int DECIM_BITS    = 8,
    parameter int SRST_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         trig_mode,
    input  logic                         trig,
    input  logic [DECIM_BITS-1:0]        decim,
    input  logic [LEN_BITS-1:0]          capture_len,
    input  logic                         sample_vld,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data,
    input  logic                         full,
    output logic                         wr_en,
    output logic [NUM_CH*DATA_WIDTH-1:0] din,
    output logic                         srst,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow,
    output logic [LEN_BITS-1:0]          wr_count
);

    localparam int CNT_MAX = (SRST_CYCLES > SETTLE_CYCLES) ? SRST_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0]    SRST_LAST   = CNT_W'(SRST_CYCLES - 1);
    localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [LEN_BITS-1:0] COUNT_SAT   = '1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAN,
        SETTLE,
        ARM,
        CAPTURE,
        DONE
    } state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cyc_cnt_reg;
    logic [DECIM_BITS-1:0]   decim_cnt_reg;
    logic [DECIM_BITS-1:0]   decim_reg;
    logic [LEN_BITS-1:0]     len_reg;
    logic                    trig_mode_reg;
    logic                    trig_prev_reg;
    logic                    wr_en_reg;
    logic [LEN_BITS-1:0]     wr_count_reg;
    logic                    overflow_reg;
    logic                    clean_entry;
    logic                    issue;
    logic                    full_stop;
    logic [LEN_BITS:0]       count_inc;

    assign count_inc = {1'b0, wr_count_reg} + 1'b1;

    // Abort beats start; start restarts from any state, including CLEAN itself.
    always_comb begin
        state_next  = state_reg;
        clean_entry = 1'b0;
        issue       = 1'b0;
        full_stop   = 1'b0;
        if (abort) begin
            state_next = IDLE;
        end else if (start) begin
            state_next  = CLEAN;
            clean_entry = 1'b1;
        end else begin
            case (state_reg)
                CLEAN: begin
                    if (cyc_cnt_reg == SRST_LAST) state_next = SETTLE;
                end
                SETTLE: begin
                    if (cyc_cnt_reg == SETTLE_LAST) state_next = trig_mode_reg ? ARM : CAPTURE;
                end
                ARM: begin
                    if (trig && !trig_prev_reg) state_next = CAPTURE;
                end
                CAPTURE: begin
                    // A zero decimation count marks a sample that must be written.
                    if (sample_vld && (decim_cnt_reg == '0)) begin
                        if (full) begin
                            full_stop  = 1'b1;
                            state_next = DONE;
                        end else begin
                            issue = 1'b1;
                            if ((len_reg != '0) && (count_inc == {1'b0, len_reg})) state_next = DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cyc_cnt_reg   <= '0;
            decim_cnt_reg <= '0;
            decim_reg     <= '0;
            len_reg       <= '0;
            trig_mode_reg <= 1'b0;
            trig_prev_reg <= 1'b0;
            wr_en_reg     <= 1'b0;
            wr_count_reg  <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            wr_en_reg <= issue;

            if (clean_entry || (state_next != state_reg)) begin
                cyc_cnt_reg <= '0;
            end else if ((state_reg == CLEAN) || (state_reg == SETTLE)) begin
                cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
            end

            if (clean_entry) begin
                wr_count_reg  <= '0;
                overflow_reg  <= 1'b0;
                decim_cnt_reg <= '0;
                trig_prev_reg <= 1'b0;
                len_reg       <= capture_len;
                trig_mode_reg <= trig_mode;
            end else begin
                trig_prev_reg <= trig;
                if (issue && (wr_count_reg != COUNT_SAT)) wr_count_reg <= wr_count_reg + 1'b1;
                if (full_stop && (len_reg != '0)) overflow_reg <= 1'b1;
                if ((state_reg == CAPTURE) && sample_vld) begin
                    decim_cnt_reg <= (decim_cnt_reg == decim_reg) ? '0 : decim_cnt_reg + 1'b1;
                end
            end

            if ((state_reg != CAPTURE) && (state_next == CAPTURE)) decim_reg <= decim;
        end
    end

    // One write-data register per channel lane.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
            logic [DATA_WIDTH-1:0] lane_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_reg <= '0;
                end else if (issue) begin
                    lane_reg <= data[gi*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            assign din[gi*DATA_WIDTH +: DATA_WIDTH] = lane_reg;
        end
    endgenerate

    assign wr_en    = wr_en_reg;
    assign srst     = (state_reg == CLEAN);
    assign busy     = (state_reg != IDLE) && (state_reg != DONE);
    assign done     = (state_reg == DONE);
    assign overflow = overflow_reg;
    assign wr_count = wr_count_reg;

endmodule

// File: tb/tb_fifo_capture_ctrl.sv
// Bench for fifo_capture_ctrl: timeline-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_fifo_capture_ctrl;

    localparam int SRST   = 4;
    localparam int SETTLE = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        trig_mode = 1'b0;
    logic        trig = 1'b0;
    logic [7:0]  decim = '0;
    logic [11:0] capture_len = '0;
    logic        sample_vld = 1'b0;
    logic [23:0] data = '0;
    logic        full = 1'b0;
    logic        wr_en, srst, busy, done, overflow;
    logic [23:0] din;
    logic [11:0] wr_count;

    fifo_capture_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .trig_mode(trig_mode), .trig(trig), .decim(decim),
        .capture_len(capture_len), .sample_vld(sample_vld), .data(data),
        .full(full), .wr_en(wr_en), .din(din), .srst(srst), .busy(busy),
        .done(done), .overflow(overflow), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: progress is measured as elapsed cycles since start, and
    // decimation as "accepted sample index is a multiple of decim+1".
    bit          m_run = 0, m_done = 0, m_hit = 0, m_tmode = 0, m_ovf = 0, m_trig_prev = 0;
    int          m_el = 0, m_nacc = 0, m_decim = 0;
    logic [11:0] m_len = '0, m_cnt = '0;
    logic        e_wr_en = 1'b0;
    logic [23:0] e_din = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_done = 0; m_hit = 0; m_ovf = 0; m_trig_prev = 0;
            m_el = 0; m_nacc = 0; m_cnt = '0; e_wr_en = 1'b0; e_din = '0;
        end else begin
            e_wr_en = 1'b0;
            if (abort) begin
                m_run = 0; m_done = 0;
            end else if (start) begin
                m_run = 1; m_done = 0; m_hit = 0; m_el = -1; m_nacc = 0;
                m_cnt = '0; m_ovf = 0; m_len = capture_len; m_tmode = trig_mode;
            end else if (m_run) begin
                if (m_el == SRST + SETTLE - 1) m_decim = int'(decim);
                if (m_el >= SRST + SETTLE) begin
                    if (m_tmode && !m_hit) begin
                        if (trig && !m_trig_prev) begin
                            m_hit = 1;
                            m_decim = int'(decim);
                        end
                    end else if (sample_vld) begin
                        if (m_nacc % (m_decim + 1) == 0) begin
                            if (full) begin
                                m_run = 0; m_done = 1; m_ovf = (m_len != 0);
                            end else begin
                                e_wr_en = 1'b1;
                                e_din = data;
                                if (m_cnt != 12'hFFF) m_cnt = m_cnt + 12'd1;
                                if (m_len != 0 && m_cnt == m_len) begin
                                    m_run = 0; m_done = 1;
                                end
                            end
                        end
                        m_nacc++;
                    end
                end
            end
            if (m_run) m_el++;
            m_trig_prev = trig;
        end
    end

    logic [23:0] wr_log[$];
    int          srst_seen = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("wr_en", 32'(wr_en), 32'(e_wr_en));
            chk("din", 32'(din), 32'(e_din));
            chk("srst", 32'(srst), 32'(m_run && (m_el < SRST)));
            chk("busy", 32'(busy), 32'(m_run));
            chk("done", 32'(done), 32'(m_done));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("wr_count", 32'(wr_count), 32'(m_cnt));
            if (wr_en) wr_log.push_back(din);
            if (srst) srst_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic strobe(input logic [23:0] v);
        sample_vld = 1'b1;
        data = v;
        tick();
        sample_vld = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int n;
        logic [23:0] exp_dec [3];
        exp_dec[0] = 24'd1; exp_dec[1] = 24'd4; exp_dec[2] = 24'd7;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_srst", 32'(srst), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_din", 32'(din), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Basic length capture, with one stray strobe during settle
        capture_len = 12'd5; decim = 8'd0; trig_mode = 1'b0;
        srst_seen = 0;
        pulse_start();
        idle(4);
        strobe(24'hABCABC);
        idle(7);
        repeat (5) begin
            strobe(24'h123456);
            idle(3);
        end
        $display("basic: wr_count=%0d done=%0b overflow=%0b writes=%0d", wr_count, done, overflow, wr_log.size());
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_wr_count", 32'(wr_count), 32'd5);
        chk("basic_overflow", 32'(overflow), 32'd0);
        chk("basic_srst_cycles", 32'(srst_seen), 32'd4);
        chk("basic_nwrites", 32'(wr_log.size()), 32'd5);
        foreach (wr_log[i]) chk("basic_din", 32'(wr_log[i]), 32'h123456);

        // Decimation by 3
        wr_log.delete();
        decim = 8'd2; capture_len = 12'd3;
        pulse_start();
        idle(12);
        for (int i = 1; i <= 9; i++) begin
            strobe(24'(i));
            idle(1);
        end
        $display("decim: writes=%0d wr_count=%0d done=%0b", wr_log.size(), wr_count, done);
        chk("decim_nwrites", 32'(wr_log.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < wr_log.size()) chk("decim_din", 32'(wr_log[i]), 32'(exp_dec[i]));
        chk("decim_wr_count", 32'(wr_count), 32'd3);
        chk("decim_done", 32'(done), 32'd1);

        // Trigger: held high before ARM, then a real rising edge
        wr_log.delete();
        decim = 8'd0; capture_len = 12'd2; trig_mode = 1'b1; trig = 1'b1;
        pulse_start();
        trig_mode = 1'b0;
        idle(12);
        strobe(24'h11);
        idle(1);
        strobe(24'h22);
        trig = 1'b0;
        tick();
        strobe(24'h33);
        trig = 1'b1;
        strobe(24'h44);
        tick();
        strobe(24'h55);
        idle(1);
        strobe(24'h66);
        idle(2);
        trig = 1'b0;
        $display("trigger: writes=%0d first=0x%0h done=%0b", wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : 24'h0, done);
        chk("trig_nwrites", 32'(wr_log.size()), 32'd2);
        if (wr_log.size() == 2) begin
            chk("trig_first", 32'(wr_log[0]), 32'h55);
            chk("trig_second", 32'(wr_log[1]), 32'h66);
        end
        chk("trig_done", 32'(done), 32'd1);

        // Full before the 4th write, length mode then fill-to-full mode
        for (int pass = 0; pass < 2; pass++) begin
            wr_log.delete();
            capture_len = (pass == 0) ? 12'd10 : 12'd0;
            pulse_start();
            idle(12);
            for (int k = 0; k < 3; k++) begin
                strobe(24'hA0 + 24'(k));
                idle(1);
            end
            full = 1'b1;
            strobe(24'hA3);
            idle(2);
            full = 1'b0;
            $display("full len=%0d: writes=%0d wr_count=%0d overflow=%0b done=%0b", capture_len, wr_log.size(), wr_count, overflow, done);
            chk("full_nwrites", 32'(wr_log.size()), 32'd3);
            chk("full_wr_count", 32'(wr_count), 32'd3);
            chk("full_overflow", 32'(overflow), (pass == 0) ? 32'd1 : 32'd0);
            chk("full_done", 32'(done), 32'd1);
        end

        // Restart mid-capture, then abort during settle
        capture_len = 12'd10;
        pulse_start();
        idle(12);
        strobe(24'h1);
        idle(1);
        strobe(24'h2);
        idle(1);
        chk("restart_pre_count", 32'(wr_count), 32'd2);
        srst_seen = 0;
        pulse_start();
        chk("restart_count_clr", 32'(wr_count), 32'd0);
        chk("restart_srst", 32'(srst), 32'd1);
        idle(5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        $display("restart/abort: srst_cycles=%0d busy=%0b", srst_seen, busy);
        chk("restart_srst_cycles", 32'(srst_seen), 32'd4);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_srst", 32'(srst), 32'd0);
        n = wr_log.size();
        repeat (4) begin
            strobe(24'h77);
            idle(1);
        end
        chk("abort_no_writes", 32'(wr_log.size()), 32'(n));

        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        idle(2);
        $display("start+abort: busy=%0b srst=%0b", busy, srst);
        chk("startabort_busy", 32'(busy), 32'd0);
        chk("startabort_srst", 32'(srst), 32'd0);

        // Async reset in the middle of a write
        capture_len = 12'd0;
        pulse_start();
        idle(12);
        strobe(24'h7);
        chk("prerst_wr_en", 32'(wr_en), 32'd1);
        chk("prerst_wr_count", 32'(wr_count), 32'd1);
        sample_vld = 1'b1;
        data = 24'h9;
        #2;
        rst_n = 1'b0;
        #1;
        sample_vld = 1'b0;
        $display("async reset: wr_en=%0b busy=%0b wr_count=%0d din=0x%0h", wr_en, busy, wr_count, din);
        chk("arst_wr_en", 32'(wr_en), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_wr_count", 32'(wr_count), 32'd0);
        chk("arst_din", 32'(din), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = wr_log.size();
        repeat (3) begin
            strobe(24'h5A);
            idle(1);
        end
        chk("postrst_no_writes", 32'(wr_log.size()), 32'(n));
        chk("postrst_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
